// File: rtl/ws2812_pkg.sv
// Shared types and timing constants for the WS2812 receive path.
// All timing values are clock counts derived from the system clock frequency.
package ws2812_pkg;

    localparam int unsigned DEF_CLK_FRE      = 32_940_000;
    localparam int unsigned DEF_WS2812_WIDTH = 24;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned PIX_CNT_W = 9;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        WAIT_HIGH = 2'd1,
        MEAS_HIGH = 2'd2
    } rx_state_t;

    function automatic int unsigned cyc_us(input int unsigned clk_fre);
        return clk_fre / 1_000_000;
    endfunction

    // High time at or above this decodes as a 1
    function automatic int unsigned thresh_cyc(input int unsigned clk_fre);
        return cyc_us(clk_fre) * 5 / 8;
    endfunction

    function automatic int unsigned min_high_cyc(input int unsigned clk_fre);
        return cyc_us(clk_fre) / 5;
    endfunction

    function automatic int unsigned max_high_cyc(input int unsigned clk_fre);
        return cyc_us(clk_fre) * 3 / 2;
    endfunction

    function automatic int unsigned reset_low_cyc(input int unsigned clk_fre);
        return cyc_us(clk_fre) * 50;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the asynchronous data line plus a delay stage
// used for edge detection.
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s2,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 line decoder: recovers LSB-first pixel words, per-frame indices and
// frame boundaries. Define WS2812_RX_FWD_EN to regenerate the downstream line.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_FRE      = DEF_CLK_FRE,
    parameter int unsigned WS2812_WIDTH = DEF_WS2812_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    din,
    output logic [WS2812_WIDTH-1:0] pixel,
    output logic                    pixel_valid,
    output logic [PIX_CNT_W-1:0]    pixel_idx,
    output logic                    frame_done,
    output logic                    bit_err,
    output logic                    dout
);

    localparam logic [CNT_W-1:0]     THRESH    = CNT_W'(thresh_cyc(CLK_FRE));
    localparam logic [CNT_W-1:0]     MIN_HIGH  = CNT_W'(min_high_cyc(CLK_FRE));
    localparam logic [CNT_W-1:0]     MAX_HIGH  = CNT_W'(max_high_cyc(CLK_FRE));
    localparam logic [CNT_W-1:0]     RESET_LOW = CNT_W'(reset_low_cyc(CLK_FRE));
    localparam logic [BIT_CNT_W-1:0] BIT_FULL  = BIT_CNT_W'(WS2812_WIDTH);

    logic s2;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .s2    (s2),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_t                state,       state_n;
    logic [CNT_W-1:0]         clk_count,   clk_count_n;
    logic [BIT_CNT_W-1:0]     bit_cnt,     bit_cnt_n;
    logic [PIX_CNT_W-1:0]     pix_cnt,     pix_cnt_n;
    logic [WS2812_WIDTH-1:0]  shreg,       shreg_n;
    logic                     cpl,         cpl_n;
    logic [PIX_CNT_W-1:0]     cpl_idx,     cpl_idx_n;
    logic                     has_pix,     has_pix_n;
    logic [WS2812_WIDTH-1:0]  pixel_n;
    logic [PIX_CNT_W-1:0]     pixel_idx_n;
    logic                     pixel_valid_n;
    logic                     frame_done_n;
    logic                     bit_err_n;
    logic [CNT_W-1:0]         cnt_inc_c;

    assign cnt_inc_c = (clk_count == '1) ? clk_count : clk_count + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SYNC;
            clk_count   <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            shreg       <= '0;
            cpl         <= 1'b0;
            cpl_idx     <= '0;
            has_pix     <= 1'b0;
            pixel       <= '0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_err     <= 1'b0;
        end else begin
            state       <= state_n;
            clk_count   <= clk_count_n;
            bit_cnt     <= bit_cnt_n;
            pix_cnt     <= pix_cnt_n;
            shreg       <= shreg_n;
            cpl         <= cpl_n;
            cpl_idx     <= cpl_idx_n;
            has_pix     <= has_pix_n;
            pixel       <= pixel_n;
            pixel_idx   <= pixel_idx_n;
            pixel_valid <= pixel_valid_n;
            frame_done  <= frame_done_n;
            bit_err     <= bit_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        clk_count_n   = clk_count;
        bit_cnt_n     = bit_cnt;
        pix_cnt_n     = pix_cnt;
        shreg_n       = shreg;
        cpl_n         = 1'b0;
        cpl_idx_n     = cpl_idx;
        has_pix_n     = has_pix;
        pixel_n       = pixel;
        pixel_idx_n   = pixel_idx;
        pixel_valid_n = 1'b0;
        frame_done_n  = 1'b0;
        bit_err_n     = 1'b0;

        // Pixel completion: close the word one cycle after its last bit, publish the next
        if (cpl) begin
            pixel_n       = shreg;
            pixel_idx_n   = cpl_idx;
            pixel_valid_n = 1'b1;
        end
        if (bit_cnt == BIT_FULL) begin
            cpl_n     = 1'b1;
            cpl_idx_n = pix_cnt;
            pix_cnt_n = pix_cnt + PIX_CNT_W'(1);
            bit_cnt_n = '0;
            has_pix_n = 1'b1;
        end

        case (state)
            SYNC: begin
                if (s2) begin
                    clk_count_n = '0;
                end else begin
                    clk_count_n = cnt_inc_c;
                    if (clk_count >= RESET_LOW) begin
                        state_n   = WAIT_HIGH;
                        bit_cnt_n = '0;
                        pix_cnt_n = '0;
                        has_pix_n = 1'b0;
                    end
                end
            end

            WAIT_HIGH: begin
                if (rise) begin
                    clk_count_n = CNT_W'(1);
                    state_n     = MEAS_HIGH;
                end else begin
                    clk_count_n = cnt_inc_c;
                    // Reset gap: a partial pixel is an error but still closes the frame
                    if (clk_count == RESET_LOW) begin
                        if (bit_cnt != '0) begin
                            bit_err_n    = 1'b1;
                            frame_done_n = 1'b1;
                        end else if (has_pix) begin
                            frame_done_n = 1'b1;
                        end
                        bit_cnt_n = '0;
                        pix_cnt_n = '0;
                        has_pix_n = 1'b0;
                    end
                end
            end

            MEAS_HIGH: begin
                if (clk_count >= MAX_HIGH || (fall && clk_count < MIN_HIGH)) begin
                    bit_err_n   = 1'b1;
                    state_n     = SYNC;
                    clk_count_n = '0;
                    bit_cnt_n   = '0;
                    pix_cnt_n   = '0;
                    has_pix_n   = 1'b0;
                end else if (fall) begin
                    shreg_n[bit_cnt] = (clk_count >= THRESH);
                    bit_cnt_n        = bit_cnt + BIT_CNT_W'(1);
                    clk_count_n      = CNT_W'(1);
                    state_n          = WAIT_HIGH;
                end else begin
                    clk_count_n = cnt_inc_c;
                end
            end

            default: begin
                state_n     = SYNC;
                clk_count_n = '0;
                bit_cnt_n   = '0;
                pix_cnt_n   = '0;
                has_pix_n   = 1'b0;
            end
        endcase
    end

`ifdef WS2812_RX_FWD_EN
    logic fwd_on;
    logic fwd_clr_c;

    // Forward only after our own pixel has been consumed, until the frame closes
    assign fwd_clr_c = frame_done_n | (state_n == SYNC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_on <= 1'b0;
        end else if (fwd_clr_c) begin
            fwd_on <= 1'b0;
        end else if (cpl) begin
            fwd_on <= 1'b1;
        end
    end

    assign dout = fwd_on & s2;
`else
    assign dout = 1'b0;
`endif

endmodule
